// File: rtl/data_mem_resp.sv
// Fixed-latency 64-bit data memory for an in-order CPU: accepts one load/store,
// stalls the core for LATENCY wait cycles, then pulses done (with err on a fault).
module data_mem_resp #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   mem [DEPTH];

    logic          fault_q;
    logic          wr_q;
    logic [AW-1:0] idx_q;
    logic [63:0]   wdata_q;

    logic          req;
    logic          req_fault;
    logic [AW-1:0] req_idx;
    logic          acc_fault;
    logic          acc_wr;
    logic [AW-1:0] acc_idx;
    logic [63:0]   acc_wdata;
    logic          enter_resp;

    // Request decode; with LATENCY=0 the access uses the live inputs, otherwise the latched copy
    always_comb begin
        req        = memRead | memWrite;
        req_fault  = (addr[2:0] != 3'd0) || (addr[63:3] >= 61'(DEPTH)) || (memRead && memWrite);
        req_idx    = AW'(addr[63:3]);
        acc_fault  = fault_q;
        acc_wr     = wr_q;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        if (state == IDLE) begin
            acc_fault = req_fault;
            acc_wr    = memWrite;
            acc_idx   = req_idx;
            acc_wdata = wdata;
        end
        enter_resp = ((state == IDLE) && req && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == CW'(1)));
        stall      = (state == WAIT) || ((state == IDLE) && req);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            fault_q <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            done <= enter_resp;
            err  <= enter_resp && acc_fault;

            // Array access happens on the edge that enters RESP
            if (enter_resp) begin
                if (acc_fault) begin
                    rdata <= '0;
                end else if (acc_wr) begin
                    mem[acc_idx] <= acc_wdata;
                end else begin
                    rdata <= mem[acc_idx];
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        fault_q <= req_fault;
                        wr_q    <= memWrite;
                        idx_q   <= req_idx;
                        wdata_q <= wdata;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning the number of 64-bit words in the memory array.
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning the number of wait cycles inserted between request acceptance and response (0..15 legal).
REQ-003 The module SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port memRead  input  1  load request from the CPU control path.
REQ-006 The module SHALL have port memWrite  input  1  store request from the CPU control path.
REQ-007 The module SHALL have port addr  input  64  byte address of the access.
REQ-008 The module SHALL have port wdata  input  64  store data.
REQ-009 The module SHALL have port rdata  output  64  load data, registered.
REQ-010 The module SHALL have port stall  output  1  CPU must hold its request and freeze the PC while high.
REQ-011 The module SHALL have port done  output  1  single-cycle pulse marking completion of the accepted access.
REQ-012 The module SHALL have port err  output  1  qualified by done, flagging a faulted access.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, a request (memRead or memWrite high) SHALL be accepted on the rising edge, latching addr, wdata and operation type.
REQ-015 On acceptance, the FSM SHALL go to WAIT with a wait counter loaded to LATENCY, or go directly to RESP when LATENCY=0.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-017 The array access SHALL occur on the edge entering RESP: a write updates mem[addr[63:3]], and a read loads rdata from mem[addr[63:3]].
REQ-018 In RESP, done SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-019 Latency SHALL be fixed: a request accepted at edge N gives done high during cycle N+1+LATENCY.
REQ-020 stall SHALL be combinational: high in IDLE while a request is present, high throughout WAIT, and low in RESP and in IDLE with no request.
REQ-021 A request still present in the cycle after RESP SHALL be treated as a new request, because the CPU is required to have advanced on done.
REQ-022 An access SHALL fault when addr[2:0] != 0 (misaligned), when addr[63:3] >= DEPTH (out of range), or when memRead and memWrite are both high.
REQ-023 A faulted access SHALL run the normal latency, assert err with done, perform no array write, and load rdata with 0.
REQ-024 err SHALL be 0 whenever done is 0.
REQ-025 rdata SHALL hold its last value across writes and idle cycles, changing only on a read completion or a fault.
REQ-026 Requests arriving while in WAIT or RESP SHALL be ignored, since the CPU holds them stable under stall.

Reset
REQ-027 When rst_n is low at a rising edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, and rdata, done and err SHALL be 0.
REQ-028 Every memory word SHALL be cleared to 0 by reset.
REQ-029 Reset asserted during WAIT SHALL abort the in-flight access with no array write and no done pulse.
REQ-030 After reset, the first request SHALL be acceptable in the first cycle in which rst_n is high.

Verification
REQ-031 Scenario: LATENCY=2, store addr=0x10, wdata=0xDEADBEEF accepted at edge 0 -> stall high for cycles 0..2; done=1, err=0 in cycle 3; mem[2]=0xDEADBEEF.
REQ-032 Scenario: load addr=0x10 following REQ-031 -> rdata=0xDEADBEEF with done in cycle 3 after acceptance; stall low in that cycle.
REQ-033 Scenario: load addr=0x13 (misaligned) and, separately, load addr=8*DEPTH (out of range) -> done=1, err=1, rdata=0, with normal latency.
REQ-034 Scenario: memRead=memWrite=1, addr=0x0, wdata=0x55 -> done=1, err=1, and mem[0] unchanged.
REQ-035 Scenario: LATENCY=0, back-to-back store then load of addr=0x8 -> each done arrives one cycle after acceptance, and the load returns the stored data.
REQ-036 Scenario: rst_n low during WAIT of a store -> no done pulse, the target word stays 0, and outputs are 0 on the next cycle.
